// File: rtl/ibpl_slot_sequencer.sv
// Time-multiplexes one shared DIOB backplane bus across SLOTS cardlet slots.
// Each slot: break-before-make turn cycle, settle window, then capture of bus inputs.
module ibpl_slot_sequencer #(
    parameter int SLOTS      = 4,
    parameter int CH_W       = 6,
    parameter int SETTLE_CYC = 8,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    nReset,
    input  logic                    enable,
    input  logic [SLOTS*CH_W-1:0]   cfg_dir,
    input  logic [SLOTS*CH_W-1:0]   cfg_out,
    output logic [SLOTS-1:0]        bus_sel,
    output logic [CH_W-1:0]         bus_dir,
    output logic [CH_W-1:0]         bus_out,
    input  logic [CH_W-1:0]         bus_in,
    output logic [SLOTS*CH_W-1:0]   slot_in,
    output logic [SLOTS-1:0]        slot_valid,
    output logic                    scan_done,
    output logic [CNT_W-1:0]        scan_count,
    output logic                    busy
);

    // state    | meaning
    // S_IDLE   | bus released, waiting for enable
    // S_TURN   | bus released for one cycle, snapshot slot config
    // S_SETTLE | slot selected and driven, settle counter running
    // S_SAMPLE | capture bus_in for the slot, advance slot index
    typedef enum logic [1:0] {S_IDLE, S_TURN, S_SETTLE, S_SAMPLE} state_t;

    localparam int IW = $clog2(SLOTS);
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t                  state_q;
    logic [IW-1:0]           idx_q;
    logic [CW-1:0]           cnt_q;
    logic [CH_W-1:0]         dir_snap_q;
    logic [CH_W-1:0]         out_snap_q;
    logic [SLOTS-1:0]        bus_sel_q;
    logic [CH_W-1:0]         bus_dir_q;
    logic [CH_W-1:0]         bus_out_q;
    logic [SLOTS*CH_W-1:0]   slot_in_q;
    logic [SLOTS-1:0]        slot_valid_q;
    logic                    scan_done_q;
    logic [CNT_W-1:0]        scan_count_q;
    logic                    busy_q;
    logic [CH_W-1:0]         cap_d;

    // Driven channels read back as the value we put on them, not the wire.
    always_comb begin
        cap_d = (bus_in & ~dir_snap_q) | (out_snap_q & dir_snap_q);
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            dir_snap_q   <= '0;
            out_snap_q   <= '0;
            bus_sel_q    <= '0;
            bus_dir_q    <= '0;
            bus_out_q    <= '0;
            slot_in_q    <= '0;
            slot_valid_q <= '0;
            scan_done_q  <= 1'b0;
            scan_count_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            scan_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    bus_sel_q <= '0;
                    bus_dir_q <= '0;
                    bus_out_q <= '0;
                    if (enable) begin
                        state_q <= S_TURN;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_TURN: begin
                    dir_snap_q <= cfg_dir[idx_q*CH_W +: CH_W];
                    out_snap_q <= cfg_out[idx_q*CH_W +: CH_W];
                    cnt_q      <= CW'(SETTLE_CYC - 1);
                    bus_sel_q  <= SLOTS'(1) << idx_q;
                    bus_dir_q  <= cfg_dir[idx_q*CH_W +: CH_W];
                    bus_out_q  <= cfg_out[idx_q*CH_W +: CH_W] & cfg_dir[idx_q*CH_W +: CH_W];
                    state_q    <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_SAMPLE: begin
                    slot_in_q[idx_q*CH_W +: CH_W] <= cap_d;
                    slot_valid_q[idx_q]           <= 1'b1;
                    if (idx_q == IW'(SLOTS - 1)) begin
                        scan_done_q  <= 1'b1;
                        scan_count_q <= scan_count_q + 1'b1;
                        idx_q        <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                    // Release the bus on the way out so the next slot always sees a turn cycle.
                    bus_sel_q <= '0;
                    bus_dir_q <= '0;
                    bus_out_q <= '0;
                    if (enable) begin
                        state_q <= S_TURN;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    bus_sel_q <= '0;
                    bus_dir_q <= '0;
                    bus_out_q <= '0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus_sel    = bus_sel_q;
    assign bus_dir    = bus_dir_q;
    assign bus_out    = bus_out_q;
    assign slot_in    = slot_in_q;
    assign slot_valid = slot_valid_q;
    assign scan_done  = scan_done_q;
    assign scan_count = scan_count_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ibpl_slot_sequencer.sv
// Bench for ibpl_slot_sequencer: slot-position model checked every cycle, plus directed literal checks.
module tb_ibpl_slot_sequencer;
    localparam int SLOTS      = 4;
    localparam int CH_W       = 6;
    localparam int SETTLE_CYC = 8;
    localparam int CNT_W      = 4;
    localparam int P          = SETTLE_CYC + 2;

    logic                  clk = 1'b0;
    logic                  nReset = 1'b0;
    logic                  enable = 1'b0;
    logic [SLOTS*CH_W-1:0] cfg_dir = '0;
    logic [SLOTS*CH_W-1:0] cfg_out = '0;
    logic [CH_W-1:0]       bus_in = '0;
    logic [SLOTS-1:0]      bus_sel;
    logic [CH_W-1:0]       bus_dir;
    logic [CH_W-1:0]       bus_out;
    logic [SLOTS*CH_W-1:0] slot_in;
    logic [SLOTS-1:0]      slot_valid;
    logic                  scan_done;
    logic [CNT_W-1:0]      scan_count;
    logic                  busy;

    ibpl_slot_sequencer #(
        .SLOTS(SLOTS), .CH_W(CH_W), .SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .nReset(nReset), .enable(enable),
        .cfg_dir(cfg_dir), .cfg_out(cfg_out),
        .bus_sel(bus_sel), .bus_dir(bus_dir), .bus_out(bus_out), .bus_in(bus_in),
        .slot_in(slot_in), .slot_valid(slot_valid),
        .scan_done(scan_done), .scan_count(scan_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a running flag plus position within the slot period
    // (0 = turn, 1..SETTLE_CYC = settle, SETTLE_CYC+1 = sample).
    bit               m_run = 1'b0;
    int               m_pos = 0;
    int               m_slot = 0;
    logic [CH_W-1:0]  m_sdir = '0;
    logic [CH_W-1:0]  m_sout = '0;
    logic [CH_W-1:0]  m_in [SLOTS] = '{default: '0};
    logic [SLOTS-1:0] m_valid = '0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic             m_done = 1'b0;
    bit               m_rst_prev = 1'b0;

    always @(posedge clk) begin
        m_rst_prev = !nReset;
        if (!nReset) begin
            m_run = 1'b0; m_pos = 0; m_slot = 0;
            m_sdir = '0; m_sout = '0; m_valid = '0; m_cnt = '0; m_done = 1'b0;
            for (int s = 0; s < SLOTS; s++) m_in[s] = '0;
        end else begin
            m_done = 1'b0;
            if (!m_run) begin
                if (enable) begin
                    m_run = 1'b1; m_pos = 0; m_slot = 0;
                end
            end else if (m_pos == 0) begin
                m_sdir = cfg_dir[m_slot*CH_W +: CH_W];
                m_sout = cfg_out[m_slot*CH_W +: CH_W];
                m_pos  = 1;
            end else if (m_pos < P - 1) begin
                m_pos++;
            end else begin
                m_in[m_slot]    = (bus_in & ~m_sdir) | (m_sout & m_sdir);
                m_valid[m_slot] = 1'b1;
                if (m_slot == SLOTS - 1) begin
                    m_done = 1'b1; m_cnt++; m_slot = 0;
                end else begin
                    m_slot++;
                end
                if (enable) m_pos = 0;
                else        m_run = 1'b0;
            end
        end
    end

    logic [SLOTS-1:0]      exp_sel;
    logic [CH_W-1:0]       exp_dir;
    logic [SLOTS*CH_W-1:0] exp_in;
    logic [SLOTS-1:0]      prev_sel = '0;
    logic                  prev_done = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_sel = (m_run && m_pos >= 1) ? (SLOTS'(1) << m_slot) : '0;
            exp_dir = (m_run && m_pos >= 1) ? m_sdir : '0;
            for (int s = 0; s < SLOTS; s++) exp_in[s*CH_W +: CH_W] = m_in[s];
            chk("bus_sel", 64'(bus_sel), 64'(exp_sel));
            chk("bus_dir", 64'(bus_dir), 64'(exp_dir));
            chk("bus_out", 64'(bus_out), 64'(exp_dir & m_sout));
            chk("slot_in", 64'(slot_in), 64'(exp_in));
            chk("slot_valid", 64'(slot_valid), 64'(m_valid));
            chk("scan_done", 64'(scan_done), 64'(m_done));
            chk("scan_count", 64'(scan_count), 64'(m_cnt));
            chk("busy", 64'(busy), 64'(m_run));
            chk("sel_popcount", 64'($countones(bus_sel) <= 1), 64'(1));
            if (prev_sel != '0 && bus_sel != '0)
                chk("break_before_make", 64'(bus_sel), 64'(prev_sel));
            if (m_rst_prev)
                chk("post_reset_zero", 64'({bus_sel, bus_dir, bus_out, scan_done, busy}), 64'(0));
            if (prev_done)
                chk("done_single_cycle", 64'(scan_done), 64'(0));
            prev_sel  = bus_sel;
            prev_done = scan_done;
        end
    end

    task automatic wait_done(output int cyc);
        int k = 0;
        while (k < 60) begin
            @(negedge clk);
            k++;
            if (scan_done) break;
        end
        cyc = k;
        if (!scan_done) chk("scan_done_timeout", 64'(scan_done), 64'(1));
    endtask

    initial begin
        int t;
        int rst_hold = 0;
        nReset  = 1'b0;
        enable  = 1'b1;
        cfg_dir = '0;
        cfg_out = '0;
        cfg_dir[1*CH_W +: CH_W] = 6'h03;
        cfg_out[1*CH_W +: CH_W] = 6'h01;
        cfg_dir[2*CH_W +: CH_W] = 6'h20;
        cfg_out[2*CH_W +: CH_W] = 6'h3F;
        bus_in = 6'h15;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_outputs", 64'({bus_sel, bus_dir, bus_out, slot_in, slot_valid, scan_done, scan_count, busy}), 64'(0));
        nReset = 1'b1;

        for (int n = 1; n <= 115; n++) begin
            @(negedge clk);
            if (n == 1)              chk("turn_after_reset", 64'(bus_sel), 64'(0));
            if (n >= 2 && n <= 10)   chk("slot0_selected", 64'(bus_sel), 64'(4'b0001));
            if (n == 11)             chk("slot0_released", 64'(bus_sel), 64'(0));
            if (n == 14)             cfg_out[1*CH_W +: CH_W] = 6'h02;
            if (n == 15)             chk("slot1_snapshot_held", 64'(bus_out), 64'(6'h01));
            if (n == 25) begin
                chk("slot2_dir", 64'(bus_dir), 64'(6'h20));
                chk("slot2_out", 64'(bus_out), 64'(6'h20));
            end
            if (n == 31) begin
                chk("slot2_capture", 64'(slot_in[2*CH_W +: CH_W]), 64'(6'h35));
                chk("slot2_valid", 64'(slot_valid[2]), 64'(1));
            end
            if (n == 41) begin
                chk("first_scan_done", 64'(scan_done), 64'(1));
                chk("first_scan_count", 64'(scan_count), 64'(1));
            end
            if (n == 42)             chk("scan_done_drops", 64'(scan_done), 64'(0));
            if (n == 55)             chk("slot1_new_cfg", 64'(bus_out), 64'(6'h02));
            if (n == 81)             chk("second_scan_done", 64'(scan_done), 64'(1));
            if (n == 94)             enable = 1'b0;
            if (n == 101) begin
                chk("partial_idle_sel", 64'(bus_sel), 64'(0));
                chk("partial_idle_busy", 64'(busy), 64'(0));
                chk("partial_slot1_capture", 64'(slot_in[1*CH_W +: CH_W]), 64'(6'h16));
            end
            if (n == 110) begin
                chk("partial_no_count", 64'(scan_count), 64'(2));
                enable = 1'b1;
            end
            if (n == 111)            chk("reenable_turn", 64'(bus_sel), 64'(0));
            if (n == 112)            chk("reenable_slot0", 64'(bus_sel), 64'(4'b0001));
        end

        wait_done(t);
        wait_done(t);
        chk("scan_period", 64'(t), 64'(SLOTS * P));
        for (int i = 0; i < 20 && scan_count != '1; i++) wait_done(t);
        chk("count_at_max", 64'(scan_count), 64'(4'hF));
        wait_done(t);
        chk("count_wrap", 64'(scan_count), 64'(0));

        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            bus_in = CH_W'($urandom);
            if ($urandom_range(0, 99) < 2) enable = ~enable;
            if ($urandom_range(0, 15) == 0) cfg_dir = (SLOTS*CH_W)'($urandom);
            if ($urandom_range(0, 15) == 0) cfg_out = (SLOTS*CH_W)'($urandom);
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) nReset = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                nReset   = 1'b0;
                rst_hold = $urandom_range(1, 3);
            end
        end
        nReset = 1'b1;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ibpl_slot_sequencer.md
Name: ibpl_slot_sequencer

Overview:
- Time-multiplexes one shared 6-bit interbackplane DIOB bus across SLOTS cardlet slots.
- Per slot: releases the bus, selects the slot, applies that slot's direction and output pattern, waits a settle time, then captures the slot's inputs into a per-slot register.
- Sits between the cardlet plugins (which supply per-slot dir/out and consume per-slot in) and the physical backplane drivers.
- Guarantees no two slots are ever selected, and no slot is ever driven, during a slot change.

Parameters:
- SLOTS, 4, number of cardlet slots sharing the bus (2..8).
- CH_W, 6, channels per slot / bus width.
- SETTLE_CYC, 8, clk cycles a slot stays selected before sampling (>=1).
- CNT_W, 16, width of scan counter.

Ports:
- clk  in  1  system clock.
- nReset  in  1  synchronous active-low reset.
- enable  in  1  run continuous scanning while high.
- cfg_dir  in  SLOTS*CH_W  per-slot direction, slot k at bits [k*CH_W +: CH_W]; 1 = output.
- cfg_out  in  SLOTS*CH_W  per-slot output data, same packing.
- bus_sel  out  SLOTS  one-hot slot select to backplane (all-zero = none).
- bus_dir  out  CH_W  output enables on the shared bus.
- bus_out  out  CH_W  data driven on the shared bus.
- bus_in  in  CH_W  data read from the shared bus.
- slot_in  out  SLOTS*CH_W  last captured value per slot, same packing.
- slot_valid  out  SLOTS  slot captured at least once since reset.
- scan_done  out  1  one-cycle pulse after the last slot of a scan is sampled.
- scan_count  out  CNT_W  completed scans, wraps modulo 2^CNT_W.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (nReset low at a clk edge): state IDLE; idx=0; bus_sel=0, bus_dir=0, bus_out=0; slot_in=0; slot_valid=0; scan_done=0; scan_count=0; busy=0. Reset mid-scan aborts immediately; the bus is released the next cycle.
- All outputs are registered. bus_out is always masked: bus_out = out & dir.
- FSM states: IDLE, TURN, SETTLE, SAMPLE.
- IDLE:
  - Bus released (sel=0, dir=0, out=0).
  - If enable=1 → TURN with idx=0.
- TURN (exactly 1 cycle):
  - sel=0, dir=0, out=0 (break-before-make).
  - Snapshot cfg_dir/cfg_out of slot idx into internal regs.
  - Load settle counter with SETTLE_CYC-1.
  - → SETTLE.
- SETTLE:
  - sel=onehot(idx); dir/out from the snapshot.
  - Config changes on cfg_* during SETTLE have no effect until that slot's next TURN.
  - Counter decrements each cycle; when 0 → SAMPLE.
  - Duration is exactly SETTLE_CYC cycles.
- SAMPLE (1 cycle; sel/dir/out held):
  - slot_in[idx] <= (bus_in & ~dir_snap) | (out_snap & dir_snap), i.e. output bits read back as the driven value.
  - slot_valid[idx] <= 1.
  - If idx==SLOTS-1: scan_done=1 next cycle, scan_count+1 (wraps), idx<=0.
  - Else idx<=idx+1.
  - Next state: TURN if enable=1, else IDLE.
- Slot period: SETTLE_CYC+2 cycles. Full scan: SLOTS*(SETTLE_CYC+2) cycles.
- enable deassert mid-slot: the current slot completes through SAMPLE, then → IDLE.
  - A partial scan does not pulse scan_done or increment scan_count.
  - The next enable restarts at slot 0.
  - Captured slot_in/slot_valid are retained.
- enable is sampled only in IDLE and SAMPLE.
- scan_done is high only for the single cycle after the final SAMPLE; it is never asserted in two consecutive cycles.
- Invariant: bus_sel has popcount <= 1 at every cycle, and bus_sel=0 whenever state is IDLE or TURN.

Test Plan:
- Reset with enable=1 held: all outputs 0 during reset. After release: bus_sel=0 for 1 cycle (TURN), then bus_sel=4'b0001 for exactly 9 cycles (SETTLE_CYC=8 plus SAMPLE).
- Slot 2 with cfg_dir=6'h20, cfg_out=6'h3F, bus_in=6'h15 → during slot 2 bus_dir=6'h20, bus_out=6'h20; slot_in[2]=6'h35; slot_valid[2]=1.
- Continuous run, SLOTS=4, SETTLE_CYC=8 → scan_done pulses every 40 cycles. Preload scan_count to 16'hFFFF via 65535 scans (or CNT_W=4 build) → next scan gives 0.
- cfg_out for slot 1 changed mid-SETTLE from 6'h01 to 6'h02 → bus_out stays 6'h01 for that slot, shows 6'h02 on the next scan.
- enable dropped in the 3rd cycle of slot 1 SETTLE → slot 1 still sampled; then IDLE with bus_sel=0. No scan_done; scan_count unchanged. Re-enable → bus_sel=4'b0001 first.
- Continuous random cfg/enable/mid-scan nReset pulses for 10k cycles → popcount(bus_sel)<=1 always; TURN cycle (sel=0, dir=0) between every slot change; outputs 0 on the cycle after any reset edge.
